counter_arbiter: RTL and testbench

Shares one CW-bit up-counter among NREQ requesters using round-robin arbitration. Each requester asks for a timed interval of len cycles. The block grants one requester, runs the shared counter for that interval, then pulses a per-requester done. It sits between client logic and the shared counter datapath, and is the only block that loads, runs or clears that counter.

---
 rtl/counter_arbiter.sv | 143 ++++++++++++++
 tb/tb_counter_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one CW-bit interval counter to NREQ requesters.
// Define COUNTER_ABORT_EN to add the abort input and aborted output.
module counter_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 6,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len_flat,
`ifdef COUNTER_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [IDW-1:0]    owner,
  output logic [CW-1:0]     count,
  output logic [NREQ-1:0]   done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [CW-1:0]   tgt_q, tgt_d;
  logic            aborted_q, aborted_d;
  logic            abort_hit;
  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [CW-1:0]   tgt_m1;

`ifdef COUNTER_ABORT_EN
  assign abort_hit = abort;
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Search starts one past the last winner, so the previous owner ranks last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[(int'(rr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  // target of 0 wraps to all-ones, giving a full 2^CW-cycle interval.
  assign tgt_m1 = tgt_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    count_d   = count_q;
    done_d    = '0;
    rr_d      = rr_q;
    tgt_d     = tgt_q;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_COUNT;
          gnt_d   = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          owner_d = win_idx;
          count_d = '0;
          rr_d    = win_idx;
          tgt_d   = len_flat[int'(win_idx)*CW +: CW];
        end
      end
      S_COUNT: begin
        if (abort_hit || (count_q == tgt_m1)) begin
          state_d   = S_DONE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          count_d   = '0;
          done_d    = gnt_q;
          aborted_d = abort_hit;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      count_q   <= '0;
      done_q    <= '0;
      rr_q      <= IDW'(NREQ - 1);
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      count_q   <= count_d;
      done_q    <= done_d;
      rr_q      <= rr_d;
      aborted_q <= aborted_d;
    end
  end

  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign count = count_q;
  assign done  = done_q;

`ifndef COUNTER_ABORT_EN
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: stimulus queues expected grants, a monitor checks them.
module tb_counter_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 6;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] len_flat;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [IDW-1:0]    owner;
  logic [CW-1:0]     count;
  logic [NREQ-1:0]   done;
`ifdef COUNTER_ABORT_EN
  logic              abort;
  logic              aborted;
`endif
  logic [CW-1:0]     len [NREQ];

  typedef struct {
    int id;
    int len;
    int gap;
    int ab;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   grants_seen = 0;
  int   k = 0;
  int   idle_run = 0;
  int   last_owner = 0;
  bit   active = 1'b0;

  counter_arbiter #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .len_flat(len_flat),
`ifdef COUNTER_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .gnt(gnt),
    .busy(busy),
    .owner(owner),
    .count(count),
    .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    len_flat = '0;
    for (int i = 0; i < NREQ; i++) len_flat[i*CW +: CW] = len[i];
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  // Monitor: samples on the falling edge, pops an expectation at each new grant.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(count), 0);
      active = 1'b0;
      idle_run = 0;
      last_owner = 0;
    end else begin
      chk("gnt_done_excl", int'(gnt & done), 0);
      if (active) begin
        if (gnt != '0) begin
          chk("cnt_gnt", int'(gnt), 1 << cur.id);
          chk("cnt_busy", int'(busy), 1);
          chk("cnt_owner", int'(owner), cur.id);
          chk("cnt_value", int'(count), k % 64);
          k++;
        end else begin
          chk("done_pulse", int'(done), 1 << cur.id);
          chk("done_busy", int'(busy), 0);
          chk("done_count", int'(count), 0);
          chk("done_owner", int'(owner), cur.id);
          chk("grant_len", k, cur.len);
`ifdef COUNTER_ABORT_EN
          chk("done_aborted", int'(aborted), cur.ab);
`endif
          active = 1'b0;
          idle_run = 1;
        end
      end else if (gnt != '0) begin
        chk("grant_done", int'(done), 0);
        if (q.size() == 0) begin
          chk("unexpected_grant", int'(gnt), 0);
        end else begin
          cur = q.pop_front();
          if (cur.gap >= 0) chk("grant_gap", idle_run, cur.gap);
          chk("grant_gnt", int'(gnt), 1 << cur.id);
          chk("grant_busy", int'(busy), 1);
          chk("grant_owner", int'(owner), cur.id);
          chk("grant_count", int'(count), 0);
          last_owner = cur.id;
          k = 1;
          active = 1'b1;
          grants_seen++;
        end
      end else begin
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_owner", int'(owner), last_owner);
`ifdef COUNTER_ABORT_EN
        chk("idle_aborted", int'(aborted), 0);
`endif
        idle_run++;
      end
    end
  end

  task automatic wait_grants(input int n);
    int t = 0;
    while (grants_seen < n && t < 300) begin
      @(posedge clk); #2;
      t++;
    end
    chk("grant_wait", int'(grants_seen >= n), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || active) && t < 300) begin
      @(posedge clk); #2;
      t++;
    end
    chk("idle_wait", int'(q.size() == 0 && !active), 1);
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic wait_count3();
    int t = 0;
    while (!(busy && count == 3) && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    chk("count3_wait", int'(busy && count == 3), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog grants=%0d required=finish", grants_seen);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req = '1;
`ifdef COUNTER_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) len[i] = CW'(2);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_owner", int'(owner), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_done", int'(done), 0);

    // All four requesting with len 2: order 0,1,2,3,0 with 2-cycle gaps.
    q.push_back('{0, 2, -1, 0});
    q.push_back('{1, 2, 2, 0});
    q.push_back('{2, 2, 2, 0});
    q.push_back('{3, 2, 2, 0});
    q.push_back('{0, 2, 2, 0});
    rst = 1'b1;
    wait_grants(5);
    req = '0;
    wait_idle();

    // Single requester, len 5.
    len[0] = CW'(5);
    q.push_back('{0, 5, -1, 0});
    req = 4'b0001;
    wait_grants(6);
    req = '0;
    wait_idle();

    // Requester 1 served, then 2 wins over 0; 0 withdraws during 2's interval.
    len[0] = CW'(2);
    len[1] = CW'(2);
    len[2] = CW'(3);
    q.push_back('{1, 2, -1, 0});
    req = 4'b0010;
    wait_grants(7);
    req = '0;
    wait_idle();
    q.push_back('{2, 3, -1, 0});
    req = 4'b0101;
    wait_grants(8);
    req = '0;
    wait_idle();

    // len 0 runs a full 64-cycle interval.
    len[3] = CW'(0);
    q.push_back('{3, 64, -1, 0});
    req = 4'b1000;
    wait_grants(9);
    req = '0;
    wait_idle();

    // Reset mid-interval clears immediately, with no done.
    len[0] = CW'(10);
    q.push_back('{0, 10, -1, 0});
    req = 4'b0001;
    wait_grants(10);
    wait_count3();
    req = '0;
    rst = 1'b0;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_owner", int'(owner), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("midrst_no_done", int'(done), 0);

`ifdef COUNTER_ABORT_EN
    // Abort at count 3 ends the interval after 4 granted cycles.
    q.push_back('{0, 4, -1, 1});
    req = 4'b0001;
    wait_grants(11);
    wait_count3();
    req = '0;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    wait_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
